// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with programmable limit, prescaled tick,
// parallel load/clear and wrap / saturate / one-shot end-of-count handling.
module counter_updown_mod #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_SAT      = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_WRAP_ALT = 2'd3
    } mode_e;

    mode_e            mode_s;
    logic [PW-1:0]    p;
    logic [PW-1:0]    p_next;
    logic             tick;
    logic             at_bound;
    logic             step_hits;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             ovf_next;
    logic             done_next;

    assign mode_s = mode_e'(mode);

    always_comb begin
        tick   = 1'b0;
        p_next = p;
        if (en) begin
            if (p == P_LAST) begin
                tick   = 1'b1;
                p_next = '0;
            end else begin
                p_next = p + PW'(1);
            end
        end
    end

    // A value loaded above limit counts as already past the up boundary.
    assign at_bound  = up ? (q >= limit) : (q == '0);
    assign q_step    = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
    assign step_hits = up ? (q_step == limit) : (q_step == '0);

    always_comb begin
        q_next    = q;
        tc_next   = 1'b0;
        ovf_next  = ovf;
        done_next = done;
        if (tick && !done) begin
            if (!at_bound) begin
                q_next  = q_step;
                tc_next = step_hits;
                if (mode_s == MODE_ONESHOT && step_hits) begin
                    done_next = 1'b1;
                end
            end else begin
                case (mode_s)
                    MODE_SAT: begin
                        ovf_next = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        done_next = 1'b1;
                    end
                    default: begin
                        q_next   = up ? '0 : limit;
                        ovf_next = 1'b1;
                        tc_next  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p    <= '0;
            q    <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else if (clr) begin
            p    <= '0;
            q    <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            p    <= '0;
            q    <= load_val;
            tc   <= 1'b0;
            done <= 1'b0;
        end else begin
            p    <= p_next;
            q    <= q_next;
            tc   <= tc_next;
            ovf  <= ovf_next;
            done <= done_next;
        end
    end

endmodule
